// File: rtl/pipeline_scoreboard_if.sv
// ID-stage request and scoreboard response bundle between the decode stage and the scoreboard.
interface pipeline_scoreboard_if #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned STAGES   = 3
);
  localparam int unsigned REG_W = $clog2(NUM_REGS);
  localparam int unsigned SEL_W = $clog2(STAGES + 1);

  logic             id_valid;
  logic [REG_W-1:0] id_rd;
  logic             id_rd_write;
  logic             id_is_load;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             mem_wait;
  logic             flush;
  logic             stall;
  logic             issue;
  logic [SEL_W-1:0] fwd_rs1_sel;
  logic [SEL_W-1:0] fwd_rs2_sel;
  logic [31:0]      stall_count;
  logic [31:0]      flush_count;

  modport master (
    output id_valid, id_rd, id_rd_write, id_is_load, id_rs1, id_rs2,
           id_rs1_used, id_rs2_used, mem_wait, flush,
    input  stall, issue, fwd_rs1_sel, fwd_rs2_sel, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rd, id_rd_write, id_is_load, id_rs1, id_rs2,
           id_rs1_used, id_rs2_used, mem_wait, flush,
    output stall, issue, fwd_rs1_sel, fwd_rs2_sel, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_scoreboard.sv
// In-order pipeline scoreboard: tracks in-flight destinations in EX..WB, resolves
// RAW hazards into a stall or a forwarding select, and counts stall/flush cycles.
module pipeline_scoreboard #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned ALU_READY  = 0,
  parameter int unsigned LOAD_READY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  pipeline_scoreboard_if.slave sb
);
  localparam int unsigned REG_W = $clog2(NUM_REGS);
  localparam int unsigned SEL_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] load_q, load_d;
  logic [REG_W-1:0]  rd_q [STAGES];
  logic [REG_W-1:0]  rd_d [STAGES];
  logic [31:0]       stall_count_q, stall_count_d;
  logic [31:0]       flush_count_q, flush_count_d;

  logic [REG_W-1:0]  src_rs   [2];
  logic              src_used [2];
  logic              src_haz  [2];
  logic [SEL_W-1:0]  src_sel  [2];
  logic              hazard_c;
  logic              stall_c;
  logic              issue_c;

  assign src_rs[0]   = sb.id_rs1;
  assign src_rs[1]   = sb.id_rs2;
  assign src_used[0] = sb.id_rs1_used;
  assign src_used[1] = sb.id_rs2_used;

  // Per-source lookup: youngest writing entry that matches decides hazard vs forward.
  for (genvar g = 0; g < 2; g++) begin : g_src
    logic             found;
    logic             haz;
    logic [SEL_W-1:0] sel;

    always_comb begin
      found = 1'b0;
      haz   = 1'b0;
      sel   = '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (!found && valid_q[i] && (rd_q[i] != '0) && (rd_q[i] == src_rs[g])) begin
          found = 1'b1;
          haz   = (i < (load_q[i] ? LOAD_READY : ALU_READY));
          sel   = SEL_W'(i + 1);
        end
      end
      if (!src_used[g] || (src_rs[g] == '0)) begin
        found = 1'b0;
      end
      src_haz[g] = found && haz;
      src_sel[g] = (found && !haz) ? sel : '0;
    end
  end

  assign hazard_c = sb.id_valid && (src_haz[0] || src_haz[1]);
  assign stall_c  = sb.mem_wait || (hazard_c && !sb.flush);
  assign issue_c  = sb.id_valid && !stall_c && !sb.flush;

  assign sb.stall       = stall_c;
  assign sb.issue       = issue_c;
  assign sb.fwd_rs1_sel = src_sel[0];
  assign sb.fwd_rs2_sel = src_sel[1];
  assign sb.stall_count = stall_count_q;
  assign sb.flush_count = flush_count_q;

  // Next entries: shift toward WB unless memory is stalled; new entry or bubble in EX.
  always_comb begin
    valid_d       = valid_q;
    load_d        = load_q;
    rd_d          = rd_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (!sb.mem_wait) begin
      for (int unsigned i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        load_d[i]  = load_q[i-1];
        rd_d[i]    = rd_q[i-1];
      end
      valid_d[0] = issue_c && sb.id_rd_write;
      load_d[0]  = issue_c && sb.id_rd_write && sb.id_is_load;
      rd_d[0]    = sb.id_rd;
      if (hazard_c && !sb.flush && (stall_count_q != '1)) begin
        stall_count_d = stall_count_q + 32'd1;
      end
      if (sb.flush && (flush_count_q != '1)) begin
        flush_count_d = flush_count_q + 32'd1;
      end
    end
  end

  // State registers; reset discards every in-flight entry and clears the counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q       <= '0;
      load_q        <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        rd_q[i] <= '0;
      end
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      load_q        <= load_d;
      rd_q          <= rd_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end
endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed scoreboard bench: the driver pushes hand-computed expectations, the monitor checks them.
module tb_pipeline_scoreboard;
  logic clock;
  logic reset;

  pipeline_scoreboard_if #(.NUM_REGS(32), .STAGES(3)) sb ();

  pipeline_scoreboard #(
    .NUM_REGS(32), .STAGES(3), .ALU_READY(0), .LOAD_READY(1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sb    (sb.slave)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic        issue;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, field, act, req);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "stall", 32'(sb.stall), 32'(e.stall));
      chk(e.name, "issue", 32'(sb.issue), 32'(e.issue));
      chk(e.name, "fwd_rs1_sel", 32'(sb.fwd_rs1_sel), 32'(e.s1));
      chk(e.name, "fwd_rs2_sel", 32'(sb.fwd_rs2_sel), 32'(e.s2));
      chk(e.name, "stall_count", sb.stall_count, e.sc);
      chk(e.name, "flush_count", sb.flush_count, e.fc);
    end
  end

  // One cycle of stimulus: apply just after the rising edge and queue the expectation.
  task automatic cyc(input string nm, input bit r, input bit v, input int rd, input bit wr,
                     input bit ld, input int rs1, input bit u1, input int rs2, input bit u2,
                     input bit mw, input bit fl, input bit e_st, input bit e_is,
                     input int e_s1, input int e_s2, input int e_sc, input int e_fc);
    exp_t e;
    @(posedge clock);
    #1;
    reset          = r;
    sb.id_valid    = v;
    sb.id_rd       = 5'(rd);
    sb.id_rd_write = wr;
    sb.id_is_load  = ld;
    sb.id_rs1      = 5'(rs1);
    sb.id_rs1_used = u1;
    sb.id_rs2      = 5'(rs2);
    sb.id_rs2_used = u2;
    sb.mem_wait    = mw;
    sb.flush       = fl;
    e.name  = nm;
    e.stall = e_st;
    e.issue = e_is;
    e.s1    = 2'(e_s1);
    e.s2    = 2'(e_s2);
    e.sc    = 32'(e_sc);
    e.fc    = 32'(e_fc);
    exp_q.push_back(e);
  endtask

  initial begin
    reset          = 1'b0;
    sb.id_valid    = 1'b0;
    sb.id_rd       = '0;
    sb.id_rd_write = 1'b0;
    sb.id_is_load  = 1'b0;
    sb.id_rs1      = '0;
    sb.id_rs1_used = 1'b0;
    sb.id_rs2      = '0;
    sb.id_rs2_used = 1'b0;
    sb.mem_wait    = 1'b0;
    sb.flush       = 1'b0;

    //   name          r v rd wr ld rs1 u1 rs2 u2 mw fl | st is s1 s2 sc fc
    cyc("rst_idle",    0,1, 0, 0, 0, 5, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
    // load-use
    cyc("ld5",         1,1, 5, 1, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
    cyc("use5_stall",  1,1, 8, 1, 0, 5, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    cyc("use5_fwd",    1,1, 8, 1, 0, 5, 1, 0, 0, 0, 0,   0, 1, 2, 0, 1, 0);
    // ALU back-to-back at increasing distance
    cyc("add6",        1,1, 6, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 0);
    cyc("rs2_6_d0",    1,1, 0, 0, 0, 0, 0, 6, 1, 0, 0,   0, 1, 0, 1, 1, 0);
    cyc("rs2_6_d1",    1,1, 0, 0, 0, 0, 0, 6, 1, 0, 0,   0, 1, 0, 2, 1, 0);
    cyc("rs2_6_d2",    1,1, 0, 0, 0, 0, 0, 6, 1, 0, 0,   0, 1, 0, 3, 1, 0);
    cyc("rs2_6_d3",    1,1, 0, 0, 0, 0, 0, 6, 1, 0, 0,   0, 1, 0, 0, 1, 0);
    // youngest wins, x0 never forwards
    cyc("w7a",         1,1, 7, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 0);
    cyc("w7b",         1,1, 7, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 0);
    cyc("rs1_7",       1,1, 0, 0, 0, 7, 1, 0, 0, 0, 0,   0, 1, 1, 0, 1, 0);
    cyc("w0",          1,1, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 0);
    cyc("rs_x0",       1,1, 0, 0, 0, 0, 1, 0, 1, 0, 0,   0, 1, 0, 0, 1, 0);
    // flush over hazard; the flushed rd=9 must not appear in EX
    cyc("ld3",         1,1, 3, 1, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 0);
    cyc("flush_haz",   1,1, 9, 1, 0, 3, 1, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0);
    cyc("post_flush",  1,1, 0, 0, 0, 3, 1, 9, 1, 0, 0,   0, 1, 2, 0, 1, 1);
    // mem_wait freeze, including mem_wait with flush
    cyc("ld4",         1,1, 4, 1, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 1);
    cyc("mw1",         1,1, 0, 0, 0, 4, 1, 0, 0, 1, 0,   1, 0, 0, 0, 1, 1);
    cyc("mw2_flush",   1,1, 0, 0, 0, 4, 1, 0, 0, 1, 1,   1, 0, 0, 0, 1, 1);
    cyc("mw3",         1,1, 0, 0, 0, 4, 1, 0, 0, 1, 0,   1, 0, 0, 0, 1, 1);
    cyc("mw_rel_haz",  1,1, 0, 0, 0, 4, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1, 1);
    cyc("ld4_in_mem",  1,1, 0, 0, 0, 4, 1, 0, 0, 0, 0,   0, 1, 2, 0, 2, 1);
    // reset mid-flight with three valid entries
    cyc("w10",         1,1,10, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 2, 1);
    cyc("w11",         1,1,11, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 2, 1);
    cyc("w12",         1,1,12, 1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 2, 1);
    cyc("full_rd",     1,1,13, 1, 0,12, 1,10, 1, 0, 0,   0, 1, 1, 3, 2, 1);
    cyc("rst_mid",     0,1, 0, 0, 0,12, 1,13, 1, 0, 0,   0, 1, 0, 0, 0, 0);
    cyc("post_rst",    1,1, 0, 0, 0,12, 1,11, 1, 0, 0,   0, 1, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    @(posedge clock);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_scoreboard.md
PIPELINE_SCOREBOARD -- requirements
Module: pipeline_scoreboard

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_REGS, 32: architectural registers; REG_W = $clog2(NUM_REGS).
- STAGES, 3: tracked post-issue stages; index 0 = EX, STAGES-1 = WB.
- ALU_READY, 0: lowest index at which a non-load result can be forwarded.
- LOAD_READY, 1: lowest index at which a load result can be forwarded.
- SEL_W = $clog2(STAGES+1): forward-select width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rd  in  REG_W  destination register.
- id_rd_write  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- id_rs1 / id_rs2  in  REG_W  source registers.
- id_rs1_used / id_rs2_used  in  1  source operand is read.
- mem_wait  in  1  data memory not ready; freeze tracking.
- flush  in  1  taken branch/jump resolved in EX; kill the ID instruction.
- stall  out  1  hold PC and IF/ID, inject a bubble into EX.
- issue  out  1  ID instruction enters EX this cycle.
- fwd_rs1_sel / fwd_rs2_sel  out  SEL_W  0 = regfile; k = forward from stage index k-1.
- stall_count  out  32  cycles with stall=1 caused by a RAW hazard.
- flush_count  out  32  cycles with flush=1.

Function
REQ-003 Keep STAGES entries {valid, rd, is_load}. An entry is "writing" when valid=1 and rd!=0.
REQ-004 Source match for rsN: id_rsN_used=1, id_rsN!=0, and at least one writing entry has rd==id_rsN. Use the lowest-index (youngest) matching entry, at index m.
REQ-005 Ready index r = LOAD_READY if that entry's is_load=1, else ALU_READY. A hazard exists when m < r.
REQ-006 fwd_rsN_sel = m+1 when a match exists and there is no hazard on that source; otherwise 0. All combinational from the current entries and ID inputs.
REQ-007 hazard = id_valid & (hazard on rs1 | hazard on rs2).
REQ-008 stall = mem_wait | (hazard & ~flush).
REQ-009 issue = id_valid & ~stall & ~flush.
REQ-010 When mem_wait=1: all entries hold and both counters hold.
REQ-011 When mem_wait=0, the entries shift one stage per clock: entry[i+1] <= entry[i]; entry[STAGES-1] retires.
REQ-012 On that shift, entry[0] <= {1, id_rd, id_is_load} when issue=1 and id_rd_write=1; otherwise entry[0] <= invalid (bubble).
REQ-013 flush only prevents the ID instruction from entering; entries already in EX..WB are untouched.
REQ-014 stall_count increments when hazard & ~flush & ~mem_wait. flush_count increments when flush & ~mem_wait. Both saturate at 32'hFFFF_FFFF and never wrap.
REQ-015 Simultaneous events:
- flush with hazard: flush wins; stall=0 unless mem_wait=1; no count on stall_count.
- mem_wait with flush: nothing changes that cycle.
- flush must be held by the source until the cycle it is sampled with mem_wait=0.
REQ-016 Timing: zero-cycle latency from the ID inputs to stall/issue/fwd. One-cycle latency from issue to entry visibility.

Reset
REQ-017 reset low asynchronously clears every entry valid and both counters to 0. Outputs then read: stall=mem_wait, issue=id_valid & ~mem_wait & ~flush, fwd sels=0.
REQ-018 Reset asserted mid-operation discards all in-flight entries. The first cycle after release behaves as an empty pipeline.

Verification (defaults STAGES=3, ALU_READY=0, LOAD_READY=1)
REQ-019 Load-use: issue load rd=5, then ID add rs1=5 -> stall=1 for exactly 1 cycle; next cycle stall=0, fwd_rs1_sel=2, stall_count=1.
REQ-020 ALU back-to-back: issue add rd=6, then ID uses rs2=6 -> stall=0, fwd_rs2_sel=1. With one bubble between them -> sel=2. With two bubbles -> sel=3. With three -> sel=0.
REQ-021 Youngest wins: issue rd=7 twice back-to-back, then ID reads rs1=7 -> fwd_rs1_sel=1, not 2. rd=0 writer followed by an rs1=0 reader -> sel=0, stall=0.
REQ-022 Flush over hazard: load rd=3 in EX, ID reads rs1=3, flush=1 -> stall=0, issue=0, entry[0] invalid next cycle, flush_count=1, stall_count=0.
REQ-023 mem_wait freeze: load rd=4 in EX, mem_wait=1 for 3 cycles -> stall=1, entries unchanged and stall_count unchanged throughout; after release the load advances to MEM.
REQ-024 Reset mid-flight: 3 valid entries, pull reset low between clock edges -> entries cleared immediately, counters read 0; a reader of those registers then gets sel=0, stall=0.
